// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the FIFO read-side stream consumer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int DATA_W_DEF  = 8;
    // The in-flight counter is sized for this maximum read latency.
    localparam int MAX_RD_LAT  = 3;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream; m_last only exists with FRAME_LAST_EN.
// Latency: n/a (wires only).
// Backpressure: m_ready from the sink stalls the stream.
interface fifo_stream_reader_if import fifo_rd_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
`ifdef FRAME_LAST_EN
    logic              m_last;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );
    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );
`else
    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_data, m_valid
    );
    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );
`endif
endinterface

// File: rtl/fifo_stream_reader_stream_out_buf.sv
// Small ring buffer that holds returned FIFO words until the sink takes them.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller's credit logic must never push when full.
module stream_out_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_dat,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_dat,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              OCC_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign do_pop = pop && (occ != '0);

    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !do_pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && do_pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Head reads as zero when empty so the output bus is clean out of reset.
    assign head_dat = (occ != '0) ? mem[rd_ptr] : '0;

    assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        push |-> (occ < OCC_W'(DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a dual-clock FIFO (read side) and re-presents its words as an in-order valid/ready stream; optional m_last via FRAME_LAST_EN.
// Latency: fifo_empty falling to m_valid rising is FIFO_RD_LAT+1 rd_clk cycles; one word per cycle sustained.
// Backpressure: reads are credit-limited so words in flight plus buffered never exceed BUF_DEPTH; m_ready low stalls pops.
module fifo_stream_reader import fifo_rd_pkg::*; #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_RD_LAT = 1,
    parameter int BUF_DEPTH   = FIFO_RD_LAT + 1,
    parameter int CNT_W       = 16,
    parameter int PKT_LEN     = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic                 en,
    fifo_stream_reader_if.master io,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_cnt
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = OCC_W + 3;

    if (FIFO_RD_LAT < 1 || FIFO_RD_LAT > MAX_RD_LAT || PKT_LEN < 2 || BUF_DEPTH < 1) begin : g_param_chk
        $error("fifo_stream_reader: unsupported parameter set");
    end

    rd_state_t              state;
    logic [FIFO_RD_LAT-1:0] vld_sr;
    logic [2:0]             inflight;
    logic [OCC_W-1:0]       occ;
    logic                   capture;
    logic                   pop;
    logic [SUM_W-1:0]       credit_sum;

    assign capture = vld_sr[FIFO_RD_LAT-1];
    assign pop     = io.m_valid & io.m_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FIFO_RD_LAT; i++) begin
            inflight = inflight + {2'b00, vld_sr[i]};
        end
    end

    // A word leaving the buffer this cycle frees its slot for a read issued now.
    assign credit_sum    = SUM_W'(occ) + SUM_W'(inflight) - SUM_W'(pop);
    assign io.fifo_rd_en = (state == RUN) & ~io.fifo_empty & (credit_sum < SUM_W'(BUF_DEPTH));

    assign io.m_valid = (occ != '0);
    assign busy       = (state != IDLE) | (vld_sr != '0) | (occ != '0);

    stream_out_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .push     (capture),
        .push_dat (io.fifo_rd_data),
        .pop      (pop),
        .head_dat (io.m_data),
        .occ      (occ)
    );

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (inflight == '0 && occ == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bit i set means a read issued i+1 cycles ago; the top bit marks data valid now.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | FIFO_RD_LAT'(io.fifo_rd_en);
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

`ifdef FRAME_LAST_EN
    localparam int FRM_W = $clog2(PKT_LEN);

    logic [FRM_W-1:0] frm_cnt;

    // Counts transfers since reset only; pausing via en keeps frame alignment.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            frm_cnt <= '0;
        end else if (pop) begin
            frm_cnt <= (frm_cnt == FRM_W'(PKT_LEN - 1)) ? '0 : frm_cnt + FRM_W'(1);
        end
    end

    assign io.m_last = io.m_valid & (frm_cnt == FRM_W'(PKT_LEN - 1));
`endif

    assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        io.fifo_rd_en |-> !io.fifo_empty);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO source, queue-level reference model, directed and random phases.
module tb_fifo_stream_reader;
    import fifo_rd_pkg::*;

    localparam int DATA_W  = 8;
    localparam int LAT     = 2;
    localparam int DEPTH   = LAT + 1;
    localparam int CNT_W   = 16;
    localparam int PKT_LEN = 4;

    logic             rd_clk   = 1'b0;
    logic             rd_rst_n = 1'b0;
    logic             en       = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) io ();

    fifo_stream_reader #(
        .DATA_W      (DATA_W),
        .FIFO_RD_LAT (LAT),
        .BUF_DEPTH   (DEPTH),
        .CNT_W       (CNT_W),
        .PKT_LEN     (PKT_LEN)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .en       (en),
        .io       (io),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #10 rd_clk = ~rd_clk;

    // Source FIFO contents and words already popped but not yet returned.
    logic [7:0] src_q[$];
    logic [7:0] env_dat_q[$];
    int         env_due_q[$];

    // Reference model: buffered words, words in flight with due cycle, run/drain/idle mode.
    logic [7:0] mbuf[$];
    logic [7:0] mp_dat[$];
    int         mp_due[$];
    int         mst;
    int unsigned mcnt;

    int cyc;
    int errors;
    int checks;
    int fail_prints;
    int pop_cnt;
    int loaded_since_rst;
    logic hold_empty;
    logic ready_drv;

    logic [7:0] xfer_log[$];
    int         xfer_cyc[$];
    logic       xfer_last[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
            end
            fail_prints++;
        end
    endtask

    task automatic load(input logic [7:0] w);
        src_q.push_back(w);
        loaded_since_rst++;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance model and source at the rising edge.
    task automatic step();
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_pop;
        logic       e_rd;
        logic       e_busy;
        logic       dut_rd;
        int         nxt;
        io.fifo_empty = (src_q.size() == 0) || hold_empty;
        io.m_ready    = ready_drv;
        io.fifo_rd_data = 8'($urandom);
        if (env_due_q.size() != 0) begin
            if (env_due_q[0] == cyc) io.fifo_rd_data = env_dat_q[0];
        end
        @(negedge rd_clk);
        e_valid = (mbuf.size() != 0);
        e_data  = e_valid ? mbuf[0] : 8'h00;
        e_pop   = e_valid && io.m_ready;
        e_rd    = (mst == 1) && !io.fifo_empty &&
                  ((mbuf.size() + mp_due.size() - (e_pop ? 1 : 0)) < DEPTH);
        e_busy  = (mst != 0) || (mp_due.size() != 0) || (mbuf.size() != 0);
        check("m_valid", 32'(io.m_valid), 32'(e_valid));
        check("m_data", 32'(io.m_data), 32'(e_data));
        check("fifo_rd_en", 32'(io.fifo_rd_en), 32'(e_rd));
        check("busy", 32'(busy), 32'(e_busy));
        check("word_cnt", 32'(word_cnt), mcnt & 32'hFFFF);
        check("rd_en_while_empty", 32'(io.fifo_rd_en & io.fifo_empty), 32'd0);
`ifdef FRAME_LAST_EN
        if (e_valid) check("m_last", 32'(io.m_last), 32'((mcnt % PKT_LEN) == PKT_LEN - 1));
`endif
        if (io.m_valid && io.m_ready) begin
            xfer_log.push_back(io.m_data);
            xfer_cyc.push_back(cyc);
`ifdef FRAME_LAST_EN
            xfer_last.push_back(io.m_last);
`else
            xfer_last.push_back(1'b0);
`endif
        end
        dut_rd = io.fifo_rd_en;
        if (dut_rd) pop_cnt++;
        // Mode change looks at occupancy before this edge's pop/capture.
        nxt = mst;
        case (mst)
            0: if (en) nxt = 1;
            1: if (!en) nxt = 2;
            default: begin
                if (en) nxt = 1;
                else if (mp_due.size() == 0 && mbuf.size() == 0) nxt = 0;
            end
        endcase
        mst = nxt;
        if (e_pop) begin
            void'(mbuf.pop_front());
            mcnt++;
        end
        if (mp_due.size() != 0) begin
            if (mp_due[0] == cyc) begin
                mbuf.push_back(mp_dat.pop_front());
                void'(mp_due.pop_front());
            end
        end
        if (e_rd && src_q.size() != 0) begin
            mp_dat.push_back(src_q[0]);
            mp_due.push_back(cyc + LAT);
        end
        @(posedge rd_clk);
        #1;
        if (env_due_q.size() != 0) begin
            if (env_due_q[0] == cyc) begin
                void'(env_dat_q.pop_front());
                void'(env_due_q.pop_front());
            end
        end
        if (dut_rd && src_q.size() != 0) begin
            env_dat_q.push_back(src_q.pop_front());
            env_due_q.push_back(cyc + LAT);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called one unit after a rising edge; low for 3 units, released before the falling edge.
    task automatic do_reset(input string tag);
        #1 rd_rst_n = 1'b0;
        #1;
        check({tag, "_rst_m_valid"}, 32'(io.m_valid), 32'd0);
        check({tag, "_rst_m_data"}, 32'(io.m_data), 32'd0);
        check({tag, "_rst_rd_en"}, 32'(io.fifo_rd_en), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_word_cnt"}, 32'(word_cnt), 32'd0);
        #2 rd_rst_n = 1'b1;
        mbuf.delete();
        mp_dat.delete();
        mp_due.delete();
        env_dat_q.delete();
        env_due_q.delete();
        mst  = 0;
        mcnt = 0;
        loaded_since_rst = src_q.size();
    endtask

    initial begin
        int L;
        int c0;
        int k;
        errors = 0; checks = 0; fail_prints = 0; pop_cnt = 0; cyc = 0;
        mst = 0; mcnt = 0; loaded_since_rst = 0;
        hold_empty = 1'b0;
        ready_drv  = 1'b1;
        io.fifo_empty   = 1'b1;
        io.fifo_rd_data = '0;
        io.m_ready      = 1'b1;
        @(posedge rd_clk);
        #1;
        do_reset("init");

        // Three words, sink always ready: back-to-back delivery after the read latency.
        en = 1'b1;
        run(3);
        load(8'h34); load(8'h28); load(8'hAB);
        L  = xfer_log.size();
        c0 = cyc;
        run(8);
        check("t1_word0", 32'(xfer_log[L]), 32'h34);
        check("t1_word1", 32'(xfer_log[L+1]), 32'h28);
        check("t1_word2", 32'(xfer_log[L+2]), 32'hAB);
        check("t1_latency", 32'(xfer_cyc[L] - c0), 32'(LAT + 1));
        check("t1_back2back_a", 32'(xfer_cyc[L+1] - xfer_cyc[L]), 32'd1);
        check("t1_back2back_b", 32'(xfer_cyc[L+2] - xfer_cyc[L+1]), 32'd1);
        check("t1_word_cnt", 32'(word_cnt), 32'd3);
        check("t1_idle_valid", 32'(io.m_valid), 32'd0);
        check("t1_idle_rd_en", 32'(io.fifo_rd_en), 32'd0);

        // Stalled sink: only BUF_DEPTH reads may be outstanding.
        ready_drv = 1'b0;
        pop_cnt = 0;
        load(8'h34); load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        run(10);
        check("t2_pops", 32'(pop_cnt), 32'd3);
        check("t2_head", 32'(io.m_data), 32'h34);
        check("t2_valid", 32'(io.m_valid), 32'd1);
        check("t2_rd_en", 32'(io.fifo_rd_en), 32'd0);
        ready_drv = 1'b1;
        run(12);
        check("t2_word_cnt", 32'(word_cnt), 32'd8);
        check("t2_src_left", 32'(src_q.size()), 32'd0);

        // en dropped right after the first pop: the read issued that cycle still lands.
        pop_cnt = 0;
        for (int i = 0; i < 10; i++) load(8'(8'h50 + i));
        step();
        en = 1'b0;
        run(12);
        check("t3_pops", 32'(pop_cnt), 32'd2);
        check("t3_src_left", 32'(src_q.size()), 32'd8);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_word_cnt", 32'(word_cnt), 32'd10);
        en = 1'b1;
        run(20);
        check("t3_word_cnt_all", 32'(word_cnt), 32'd18);

        // Reset with two words buffered and one in flight: those are lost, the fourth follows.
        ready_drv = 1'b0;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        k = 0;
        while (mbuf.size() != 2 && k < 30) begin
            step();
            k++;
        end
        check("t4_fill_in_time", 32'(k < 30), 32'd1);
        do_reset("t4");
        ready_drv = 1'b1;
        L = xfer_log.size();
        run(10);
        check("t4_next_word", 32'(xfer_log[L]), 32'hA4);
        check("t4_word_cnt", 32'(word_cnt), 32'd1);
        check("t4_src_left", 32'(src_q.size()), 32'd0);

        // Random phase: toggling empty, random backpressure, en and refills.
        for (int i = 0; i < 1500; i++) begin
            if (i < 300) hold_empty = ~hold_empty;
            else         hold_empty = ($urandom_range(0, 3) == 0);
            ready_drv = ($urandom_range(0, 9) < 7);
            en        = ($urandom_range(0, 15) != 0);
            if (src_q.size() < 6 && $urandom_range(0, 1) == 1) load(8'($urandom));
            step();
        end
        hold_empty = 1'b0;
        ready_drv  = 1'b1;
        en         = 1'b1;
        run(40);
        check("t5_src_drained", 32'(src_q.size()), 32'd0);
        check("t5_all_delivered", 32'(word_cnt), 32'(loaded_since_rst) & 32'hFFFF);
        en = 1'b0;
        run(10);
        check("t5_busy_low", 32'(busy), 32'd0);

`ifdef FRAME_LAST_EN
        do_reset("t6");
        en = 1'b1;
        L = xfer_log.size();
        for (int i = 0; i < 8; i++) load(8'(8'hC0 + i));
        run(20);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_last%0d", i), 32'(xfer_last[L+i]), 32'(i == 3 || i == 7));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
